// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants for the 2048 display path.
// Sync windows are stored as inclusive start/end pixel or line positions.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

endpackage

// File: rtl/vga_scan_out_scan_counter.sv
// Enable-gated wrap counter: counts 0..MAX, returning to 0 on the enabled tick at MAX.
// wrap is combinational so a downstream counter can chain off it in the same tick.
module scan_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX = 799
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(MAX);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_scan_out.sv
// Raster timing generator and registered pixel output stage for the 2048 VGA display.
// All timing advances on pix_en ticks; outputs lag the request coordinates by one tick.
module vga_scan_out #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int RGB_W    = vga_timing_pkg::RGB_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pix_en,
  output logic [vga_timing_pkg::COORD_W-1:0] pix_x,
  output logic [vga_timing_pkg::COORD_W-1:0] pix_y,
  output logic                               pix_rd,
  input  logic [RGB_W-1:0]                   pix_rgb,
  output logic [RGB_W-1:0]                   vga_rgb,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               line_start,
  output logic                               frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_VIS = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_LO = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_wrap;
  logic               v_wrap_unused;
  logic               req_valid;

  scan_counter #(.MAX(H_TOTAL - 1)) u_h_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .count (h),
    .wrap  (h_wrap)
  );

  scan_counter #(.MAX(V_TOTAL - 1)) u_v_count (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en && h_wrap),
    .count (v),
    .wrap  (v_wrap_unused)
  );

  // Stage 0: register the request coordinate. req_valid marks that pix_x/pix_y
  // hold a real counted coordinate rather than the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rd    <= 1'b0;
      req_valid <= 1'b0;
    end else if (pix_en) begin
      pix_x     <= h;
      pix_y     <= v;
      pix_rd    <= (h < H_VIS) && (v < V_VIS);
      req_valid <= 1'b1;
    end
  end

  // Stage 1: colour and syncs decoded from the stage-0 coordinate so they stay
  // aligned; the start pulses last one clk regardless of pix_en spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        vga_rgb     <= pix_rd ? pix_rgb : '0;
        hsync       <= !((pix_x >= HS_LO) && (pix_x <= HS_HI));
        vsync       <= !((pix_y >= VS_LO) && (pix_y <= VS_HI));
        line_start  <= req_valid && (pix_x == '0);
        frame_start <= req_valid && (pix_x == '0) && (pix_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: full horizontal timing, vertical timing shrunk
// to 10 lines (4 active, 2 FP, 2 sync, 2 BP) so whole frames fit in a short run.
module tb_vga_scan_out;

  import vga_timing_pkg::*;

  localparam int TB_V_ACTIVE = 4;
  localparam int TB_V_FP     = 2;
  localparam int TB_V_SYNC   = 2;
  localparam int TB_V_BP     = 2;
  localparam int TB_V_TOTAL  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [11:0] pix_rgb = '0;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_rd;
  logic [11:0] vga_rgb;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  vga_scan_out #(
    .V_ACTIVE (TB_V_ACTIVE),
    .V_FP     (TB_V_FP),
    .V_SYNC   (TB_V_SYNC),
    .V_BP     (TB_V_BP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rd      (pix_rd),
    .pix_rgb     (pix_rgb),
    .vga_rgb     (vga_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        rd;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        care;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   compared = 0;
  int   mismatched = 0;
  int   tick_idx = 0;
  logic cont_mode = 1'b0;
  logic en_seen = 1'b0;

  int   clk_count = 0;
  int   since_ls = 0;
  logic have_ls = 1'b0;
  int   hs_run = 0;
  int   vs_run = 0;
  logic have_fs = 1'b0;
  int   last_fs_clk = 0;
  int   n_hs_runs = 0;
  int   n_vs_runs = 0;
  int   n_fs = 0;

  // Raster index k counts pixels from (0,0) of a fresh frame.
  function automatic logic [9:0] coord_x(input int k);
    return 10'(k % 800);
  endfunction

  function automatic logic [9:0] coord_y(input int k);
    return 10'((k / 800) % TB_V_TOTAL);
  endfunction

  function automatic logic active(input int k);
    return ((k % 800) < 640) && (((k / 800) % TB_V_TOTAL) < TB_V_ACTIVE);
  endfunction

  function automatic logic [11:0] pattern(input int k);
    logic [9:0] x;
    logic [9:0] y;
    x = coord_x(k);
    y = coord_y(k);
    return {x[3:0], y[3:0], 4'hA};
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = '0; e.y = '0; e.rd = 1'b0; e.rgb = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.ls = 1'b0; e.fs = 1'b0; e.care = 1'b1;
    return e;
  endfunction

  // After tick n the request side shows pixel n-1, the output side pixel n-2.
  function automatic exp_t make_exp(input int n);
    exp_t e;
    int   k;
    int   r;
    k = n - 2;
    r = n - 1;
    e.x  = coord_x(r);
    e.y  = coord_y(r);
    e.rd = active(r);
    if (n >= 2) begin
      e.rgb  = active(k) ? pattern(k) : 12'h000;
      e.hs   = !((coord_x(k) >= 10'd656) && (coord_x(k) <= 10'd751));
      e.vs   = !((coord_y(k) >= 10'd6) && (coord_y(k) <= 10'd7));
      e.ls   = (coord_x(k) == 10'd0);
      e.fs   = (coord_x(k) == 10'd0) && (coord_y(k) == 10'd0);
      e.care = 1'b1;
    end else begin
      e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1;
      e.ls = 1'b0; e.fs = 1'b0; e.care = 1'b0;
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s (tick %0d, t=%0t): got %0h, want %0h", name, tick_idx, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    cmp({tag, "_pix_x"},   32'(pix_x),   32'(e.x));
    cmp({tag, "_pix_y"},   32'(pix_y),   32'(e.y));
    cmp({tag, "_pix_rd"},  32'(pix_rd),  32'(e.rd));
    cmp({tag, "_vga_rgb"}, 32'(vga_rgb), 32'(e.rgb));
    cmp({tag, "_hsync"},   32'(hsync),   32'(e.hs));
    cmp({tag, "_vsync"},   32'(vsync),   32'(e.vs));
    if (e.care) begin
      cmp({tag, "_line_start"},  32'(line_start),  32'(e.ls));
      cmp({tag, "_frame_start"}, 32'(frame_start), 32'(e.fs));
    end
  endtask

  // One clk of stimulus; a pix_en tick also queues the response it must produce.
  task automatic applyStimulus(input logic en);
    if (en) begin
      tick_idx++;
      pix_rgb = (tick_idx >= 2) ? pattern(tick_idx - 2) : 12'hFFF;
      exp_q.push_back(make_exp(tick_idx));
    end else begin
      pix_rgb = 12'h3C3;
    end
    pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 checkOutput(reset_exp(), "async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick_idx = 0;
    rst_n = 1'b1;
  endtask

  task automatic monitor_step();
    exp_t e;
    if (!rst_n) begin
      last_exp = reset_exp();
      hs_run = 0; vs_run = 0; since_ls = 0;
      have_ls = 1'b0; have_fs = 1'b0;
      return;
    end
    clk_count++;
    if (en_seen) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_empty: output tick with nothing queued at t=%0t", $time);
        return;
      end
      e = exp_q.pop_front();
      checkOutput(e, "tick");
      last_exp = e;
      if (e.care) begin
        since_ls++;
        if (line_start) begin
          if (have_ls) cmp("line_period_ticks", 32'(since_ls), 32'd800);
          have_ls = 1'b1;
          since_ls = 0;
        end
        if (!hsync) begin
          hs_run++;
        end else if (hs_run > 0) begin
          cmp("hsync_low_ticks", 32'(hs_run), 32'd96);
          n_hs_runs++;
          hs_run = 0;
        end
      end
    end else begin
      e = last_exp;
      e.ls = 1'b0;
      e.fs = 1'b0;
      e.care = 1'b1;
      checkOutput(e, "hold");
    end
    if (!vsync) begin
      vs_run++;
    end else if (vs_run > 0) begin
      if (cont_mode) begin
        cmp("vsync_low_clk", 32'(vs_run), 32'd1600);
        n_vs_runs++;
      end
      vs_run = 0;
    end
    if (frame_start) begin
      if (have_fs && cont_mode) begin
        cmp("frame_period_clk", 32'(clk_count - last_fs_clk), 32'd8000);
        n_fs++;
      end
      have_fs = cont_mode;
      last_fs_clk = clk_count;
    end
  endtask

  always @(posedge clk) en_seen <= pix_en && rst_n;

  always @(negedge clk) monitor_step();

  initial begin
    int guard;
    $display("[TB] full-size frame %0d x %0d = %0d clk at pix_en high; hsync %0d..%0d, vsync %0d..%0d",
             H_TOTAL, V_TOTAL, H_TOTAL * V_TOTAL, H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END);
    rst_n = 1'b0;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(reset_exp(), "reset_state");
    rst_n = 1'b1;

    // First 300 ticks at the nominal rate with a 50-clk stall, then reset at h=300.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) repeat (50) applyStimulus(1'b0);
      applyStimulus(1'b1);
      repeat (3) applyStimulus(1'b0);
    end
    do_reset();

    for (int i = 0; i < 1700; i++) begin
      if (i == 1000) repeat (50) applyStimulus(1'b0);
      applyStimulus(1'b1);
      repeat (3) applyStimulus(1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1);
      repeat ($urandom_range(0, 6)) applyStimulus(1'b0);
    end

    // pix_en held high: two full frames, then reset inside both sync pulses.
    cont_mode = 1'b1;
    for (int i = 0; i < 16500; i++) applyStimulus(1'b1);
    guard = 0;
    while ((((tick_idx - 2) % 8000) != 5500) && (guard < 9000)) begin
      applyStimulus(1'b1);
      guard++;
    end
    cmp("reach_sync_region", 32'(guard < 9000), 32'd1);
    applyStimulus(1'b0);
    cmp("pre_reset_hsync_low", 32'(hsync), 32'd0);
    cmp("pre_reset_vsync_low", 32'(vsync), 32'd0);
    do_reset();

    // Fresh frame through the (799, 9) -> (0, 0) wrap and into the next frame.
    for (int i = 0; i < 8010; i++) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);

    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    cmp("hsync_runs_seen", 32'(n_hs_runs > 0), 32'd1);
    cmp("vsync_runs_seen", 32'(n_vs_runs > 0), 32'd1);
    cmp("frame_periods_seen", 32'(n_fs > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
